// File: rtl/dram_peek_bridge_if.sv
// Memory-controller side of the DRAM peek bridge: command port, write FIFO and read FIFO.
interface dram_peek_bridge_if;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        wr_full;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_empty;

    modport master (
        output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_data, wr_mask, rd_en,
        input  cmd_full, wr_full, rd_data, rd_empty
    );

    modport slave (
        input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_data, wr_mask, rd_en,
        output cmd_full, wr_full, rd_data, rd_empty
    );
endinterface

// File: rtl/dram_peek_bridge.sv
// Single-word DRAM peek/poke bridge from a CSR front-end to a memory-controller port, with a one-entry pending slot.
// Optional read timeout is enabled by defining DRAM_PEEK_TIMEOUT_EN.
module dram_peek_bridge (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [27:0]          addr_i,
    input  logic [31:0]          data_i,
    input  logic                 we_i,
    input  logic                 pop_i,
    output logic [31:0]          data_o,
    output logic                 ack_o,
    output logic                 overflow_o,
    output logic                 timeout_o,
    dram_peek_bridge_if.master   mc
);

    localparam int unsigned AW  = 28;
    localparam int unsigned DW  = 32;
    localparam int unsigned BAW = 30;
    localparam int unsigned TW  = 16;

    localparam logic [2:0]    INSTR_WR     = 3'b000;
    localparam logic [2:0]    INSTR_RD     = 3'b001;
    localparam logic [DW-1:0] TIMEOUT_DATA = 32'hdead_beef;

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, RD_ACK
    } state_t;

    typedef struct packed {
        logic          valid;
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } slot_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    slot_t          slot_q, slot_d;
    logic           ovf_d;

    logic           cmd_en_d, wr_en_d, rd_en_d, ack_d;
    logic [2:0]     cmd_instr_d;
    logic [BAW-1:0] cmd_addr_d;
    logic [DW-1:0]  wr_data_d, data_d;
    logic           to_hit_c;

    assign mc.cmd_bl  = 6'd0;
    assign mc.wr_mask = 4'h0;

`ifdef DRAM_PEEK_TIMEOUT_EN
    // Counts RD_WAIT cycles with no data; fires on the 65535th such cycle.
    localparam logic [TW-1:0] TO_LAST = TW'(65534);
    logic [TW-1:0] to_cnt_q;

    assign to_hit_c = (state_q == RD_WAIT) && mc.rd_empty && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            timeout_o <= 1'b0;
        end else begin
            if ((state_q == RD_WAIT) && mc.rd_empty && !to_hit_c) begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end else begin
                to_cnt_q <= '0;
            end
            if (to_hit_c) begin
                timeout_o <= 1'b1;
            end
        end
    end
`else
    assign to_hit_c  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // State, latched request, pending slot and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            slot_q           <= '0;
            overflow_o       <= 1'b0;
            mc.cmd_en        <= 1'b0;
            mc.cmd_instr     <= INSTR_WR;
            mc.cmd_byte_addr <= '0;
            mc.wr_en         <= 1'b0;
            mc.wr_data       <= '0;
            mc.rd_en         <= 1'b0;
            ack_o            <= 1'b0;
            data_o           <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            slot_q           <= slot_d;
            overflow_o       <= ovf_d;
            mc.cmd_en        <= cmd_en_d;
            mc.cmd_instr     <= cmd_instr_d;
            mc.cmd_byte_addr <= cmd_addr_d;
            mc.wr_en         <= wr_en_d;
            mc.wr_data       <= wr_data_d;
            mc.rd_en         <= rd_en_d;
            ack_o            <= ack_d;
            data_o           <= data_d;
        end
    end

    // Next state plus request acceptance into the FSM or the pending slot.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        slot_d  = slot_q;
        ovf_d   = overflow_o;

        case (state_q)
            IDLE: begin
                if (we_i) begin
                    state_d = WR_DATA;
                    addr_d  = addr_i;
                    wdata_d = data_i;
                    if (pop_i) begin
                        if (slot_q.valid) begin
                            ovf_d = 1'b1;
                        end else begin
                            slot_d = '{valid: 1'b1, is_wr: 1'b0, addr: addr_i, data: data_i};
                        end
                    end
                end else if (pop_i) begin
                    state_d = RD_CMD;
                    addr_d  = addr_i;
                end else if (slot_q.valid) begin
                    state_d      = slot_q.is_wr ? WR_DATA : RD_CMD;
                    addr_d       = slot_q.addr;
                    wdata_d      = slot_q.data;
                    slot_d.valid = 1'b0;
                end
            end
            WR_DATA: if (!mc.wr_full)  state_d = WR_CMD;
            WR_CMD:  if (!mc.cmd_full) state_d = IDLE;
            RD_CMD:  if (!mc.cmd_full) state_d = RD_WAIT;
            RD_WAIT: if (!mc.rd_empty || to_hit_c) state_d = RD_ACK;
            RD_ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Busy: park one request; a simultaneous read or a full slot means a drop.
        if ((state_q != IDLE) && (we_i || pop_i)) begin
            if (slot_q.valid) begin
                ovf_d = 1'b1;
            end else begin
                slot_d = '{valid: 1'b1, is_wr: we_i, addr: addr_i, data: data_i};
                if (we_i && pop_i) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // Next values of the controller strobes and read-return outputs.
    always_comb begin
        cmd_en_d    = 1'b0;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        ack_d       = 1'b0;
        cmd_instr_d = mc.cmd_instr;
        cmd_addr_d  = mc.cmd_byte_addr;
        wr_data_d   = mc.wr_data;
        data_d      = data_o;

        case (state_q)
            WR_DATA: begin
                if (!mc.wr_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = wdata_q;
                end
            end
            WR_CMD: begin
                if (!mc.cmd_full) begin
                    cmd_en_d    = 1'b1;
                    cmd_instr_d = INSTR_WR;
                    cmd_addr_d  = {addr_q, 2'b00};
                end
            end
            RD_CMD: begin
                if (!mc.cmd_full) begin
                    cmd_en_d    = 1'b1;
                    cmd_instr_d = INSTR_RD;
                    cmd_addr_d  = {addr_q, 2'b00};
                end
            end
            RD_WAIT: begin
                if (!mc.rd_empty) begin
                    rd_en_d = 1'b1;
                    data_d  = mc.rd_data;
                end else if (to_hit_c) begin
                    data_d = TIMEOUT_DATA;
                end
            end
            RD_ACK:  ack_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dram_peek_bridge.sv
// Directed self-checking bench for dram_peek_bridge with a strobe scoreboard.
module tb_dram_peek_bridge;

    logic        clk;
    logic        rst_n;
    logic [27:0] addr_i;
    logic [31:0] data_i;
    logic        we_i;
    logic        pop_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        overflow_o;
    logic        timeout_o;

    dram_peek_bridge_if mc ();

    dram_peek_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .we_i       (we_i),
        .pop_i      (pop_i),
        .data_o     (data_o),
        .ack_o      (ack_o),
        .overflow_o (overflow_o),
        .timeout_o  (timeout_o),
        .mc         (mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int n_cmd = 0;
    int n_rd  = 0;
    int n_ack = 0;

    logic [31:0] exp_wr[$];
    logic [32:0] exp_cmd[$];
    logic [31:0] exp_rd[$];

    logic [31:0] m_wr;
    logic [32:0] m_cmd;
    logic [31:0] m_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every controller strobe and ack must match the next expectation.
    always @(negedge clk) begin
        if (mc.wr_en === 1'b1) begin
            n_wr++;
            chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
            if (exp_wr.size() != 0) begin
                m_wr = exp_wr.pop_front();
                chk("wr_data", 64'(mc.wr_data), 64'(m_wr));
                chk("wr_mask", 64'(mc.wr_mask), 64'd0);
            end
        end
        if (mc.cmd_en === 1'b1) begin
            n_cmd++;
            chk("cmd_expected", 64'(exp_cmd.size() != 0), 64'd1);
            if (exp_cmd.size() != 0) begin
                m_cmd = exp_cmd.pop_front();
                chk("cmd_instr_addr", 64'({mc.cmd_instr, mc.cmd_byte_addr}), 64'(m_cmd));
                chk("cmd_bl", 64'(mc.cmd_bl), 64'd0);
            end
        end
        if (mc.rd_en === 1'b1) n_rd++;
        if (ack_o === 1'b1) begin
            n_ack++;
            chk("ack_expected", 64'(exp_rd.size() != 0), 64'd1);
            if (exp_rd.size() != 0) begin
                m_rd = exp_rd.pop_front();
                chk("ack_data", 64'(data_o), 64'(m_rd));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle request pulse, starting and ending on a falling edge.
    task automatic drive(input logic we, input logic pop, input logic [27:0] a, input logic [31:0] d);
        we_i   = we;
        pop_i  = pop;
        addr_i = a;
        data_i = d;
        @(negedge clk);
        we_i  = 1'b0;
        pop_i = 1'b0;
    endtask

    // Bounded wait for a strobe: 0 cmd_en, 1 rd_en, 2 ack_o. Expiry is a failed comparison.
    task automatic wait_for(input string tag, input int which, input int max, output int n);
        logic hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < max) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = mc.cmd_en;
                1:       hit = mc.rd_en;
                default: hit = ack_o;
            endcase
        end
        chk(tag, 64'(hit), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
    endtask

    int b_wr, b_cmd, b_rd, b_ack, n;

    task automatic snap();
        b_wr = n_wr; b_cmd = n_cmd; b_rd = n_rd; b_ack = n_ack;
    endtask

    initial begin
        rst_n = 1'b0; addr_i = '0; data_i = '0; we_i = 1'b0; pop_i = 1'b0;
        mc.cmd_full = 1'b0; mc.wr_full = 1'b0; mc.rd_empty = 1'b1; mc.rd_data = '0;
        cycles(3);

        // Reset state
        chk("rst_data_o",   64'(data_o),     64'd0);
        chk("rst_ack_o",    64'(ack_o),      64'd0);
        chk("rst_cmd_en",   64'(mc.cmd_en),  64'd0);
        chk("rst_wr_en",    64'(mc.wr_en),   64'd0);
        chk("rst_rd_en",    64'(mc.rd_en),   64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_timeout",  64'(timeout_o),  64'd0);
        rst_n = 1'b1;
        cycles(1);

        // Single write
        snap();
        exp_wr.push_back(32'h1234_5678);
        exp_cmd.push_back({3'b000, 30'h40});
        drive(1'b1, 1'b0, 28'h000_0010, 32'h1234_5678);
        cycles(6);
        chk("wr_count",     64'(n_wr - b_wr),   64'd1);
        chk("wr_cmd_count", 64'(n_cmd - b_cmd), 64'd1);
        chk("wr_no_ack",    64'(n_ack - b_ack), 64'd0);

        // Single read, data arrives two cycles after the command
        snap();
        exp_cmd.push_back({3'b001, 30'h10});
        exp_rd.push_back(32'hcafe_f00d);
        drive(1'b0, 1'b1, 28'h000_0004, 32'h0);
        wait_for("rd_cmd_seen", 0, 20, n);
        cycles(2);
        mc.rd_empty = 1'b0;
        mc.rd_data  = 32'hcafe_f00d;
        wait_for("rd_en_seen", 1, 20, n);
        mc.rd_empty = 1'b1;
        mc.rd_data  = 32'h0;
        wait_for("rd_ack_seen", 2, 20, n);
        @(negedge clk);
        chk("rd_ack_one_cycle", 64'(ack_o),  64'd0);
        chk("rd_data_held",     64'(data_o), 64'hcafe_f00d);
        cycles(2);
        chk("rd_rd_en_count", 64'(n_rd - b_rd),   64'd1);
        chk("rd_ack_count",   64'(n_ack - b_ack), 64'd1);

        // Read latency with idle controller and data already present
        snap();
        mc.rd_empty = 1'b0;
        mc.rd_data  = 32'ha5a5_5a5a;
        exp_cmd.push_back({3'b001, 30'h3fc});
        exp_rd.push_back(32'ha5a5_5a5a);
        drive(1'b0, 1'b1, 28'h000_00ff, 32'h0);
        wait_for("lat_ack_seen", 2, 20, n);
        chk("read_latency", 64'(n + 1), 64'd4);
        mc.rd_empty = 1'b1;
        cycles(3);
        chk("lat_rd_en_count", 64'(n_rd - b_rd), 64'd1);

        // Command backpressure on a write
        snap();
        mc.cmd_full = 1'b1;
        exp_wr.push_back(32'hbeef_cafe);
        exp_cmd.push_back({3'b000, 30'h400});
        drive(1'b1, 1'b0, 28'h000_0100, 32'hbeef_cafe);
        cycles(10);
        chk("bp_cmd_held", 64'(n_cmd - b_cmd), 64'd0);
        mc.cmd_full = 1'b0;
        wait_for("bp_cmd_seen", 0, 5, n);
        chk("bp_cmd_first_cycle", 64'(n), 64'd1);
        cycles(4);
        chk("bp_cmd_once", 64'(n_cmd - b_cmd), 64'd1);

        // Write then read on the next cycle: read goes through the pending slot
        snap();
        mc.rd_empty = 1'b0;
        mc.rd_data  = 32'h3333_4444;
        exp_wr.push_back(32'h1111_2222);
        exp_cmd.push_back({3'b000, 30'h80});
        exp_cmd.push_back({3'b001, 30'h20});
        exp_rd.push_back(32'h3333_4444);
        drive(1'b1, 1'b0, 28'h000_0020, 32'h1111_2222);
        drive(1'b0, 1'b1, 28'h000_0008, 32'h0);
        cycles(12);
        mc.rd_empty = 1'b1;
        chk("b2b_ack_count", 64'(n_ack - b_ack), 64'd1);
        chk("b2b_overflow",  64'(overflow_o),    64'd0);

        // Write and read in the same cycle from IDLE
        snap();
        mc.rd_empty = 1'b0;
        mc.rd_data  = 32'h5555_6666;
        exp_wr.push_back(32'h7777_8888);
        exp_cmd.push_back({3'b000, 30'h100});
        exp_cmd.push_back({3'b001, 30'h100});
        exp_rd.push_back(32'h5555_6666);
        drive(1'b1, 1'b1, 28'h000_0040, 32'h7777_8888);
        cycles(12);
        mc.rd_empty = 1'b1;
        chk("same_ack_count", 64'(n_ack - b_ack), 64'd1);
        chk("same_wr_count",  64'(n_wr - b_wr),   64'd1);
        chk("same_overflow",  64'(overflow_o),    64'd0);

        // Third request while busy with a full slot is dropped
        snap();
        mc.rd_empty = 1'b0;
        mc.rd_data  = 32'h9999_aaaa;
        exp_wr.push_back(32'h0bad_f00d);
        exp_cmd.push_back({3'b000, 30'h200});
        exp_cmd.push_back({3'b001, 30'h24});
        exp_rd.push_back(32'h9999_aaaa);
        drive(1'b1, 1'b0, 28'h000_0080, 32'h0bad_f00d);
        drive(1'b0, 1'b1, 28'h000_0009, 32'h0);
        drive(1'b1, 1'b0, 28'h000_0030, 32'hdead_0001);
        cycles(12);
        mc.rd_empty = 1'b1;
        chk("ovf_flag",      64'(overflow_o),    64'd1);
        chk("ovf_wr_count",  64'(n_wr - b_wr),   64'd1);
        chk("ovf_ack_count", 64'(n_ack - b_ack), 64'd1);
        do_reset();
        chk("ovf_cleared", 64'(overflow_o), 64'd0);

        // Reset in the middle of a stalled write abandons it
        snap();
        mc.wr_full = 1'b1;
        drive(1'b1, 1'b0, 28'h000_0050, 32'hfeed_face);
        cycles(2);
        rst_n = 1'b0;
        @(negedge clk);
        mc.wr_full = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(6);
        chk("midrst_no_wr",  64'(n_wr - b_wr),   64'd0);
        chk("midrst_no_cmd", 64'(n_cmd - b_cmd), 64'd0);

`ifdef DRAM_PEEK_TIMEOUT_EN
        // Read with no data ever returned
        snap();
        exp_cmd.push_back({3'b001, 30'h1c});
        exp_rd.push_back(32'hdead_beef);
        drive(1'b0, 1'b1, 28'h000_0007, 32'h0);
        wait_for("to_ack_seen", 2, 70000, n);
        chk("to_latency", 64'(n + 1), 64'd65538);
        chk("to_flag",    64'(timeout_o), 64'd1);
        chk("to_no_rd_en", 64'(n_rd - b_rd), 64'd0);
        do_reset();
        chk("to_cleared", 64'(timeout_o), 64'd0);
`else
        chk("timeout_tied_low", 64'(timeout_o), 64'd0);
`endif

        chk("exp_wr_drained",  64'(exp_wr.size()),  64'd0);
        chk("exp_cmd_drained", 64'(exp_cmd.size()), 64'd0);
        chk("exp_rd_drained",  64'(exp_rd.size()),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_peek_bridge.md
DRAM_PEEK_BRIDGE -- requirements
Module: dram_peek_bridge

Interface
REQ-001 Ports SHALL be as listed; one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  system clock; all logic on posedge.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 addr_i  in  28  word address from SPI CSR front-end (dram0_addr).
REQ-005 data_i  in  32  write data (dram0_data).
REQ-006 we_i  in  1  one-cycle write request pulse.
REQ-007 pop_i  in  1  one-cycle read request pulse.
REQ-008 data_o  out  32  read data; valid when ack_o is high, held until next ack_o.
REQ-009 ack_o  out  1  one-cycle read-complete pulse.
REQ-010 cmd_en / cmd_instr[2:0] / cmd_bl[5:0] / cmd_byte_addr[29:0]  out; cmd_full  in  memory-controller command port.
REQ-011 wr_en / wr_data[31:0] / wr_mask[3:0]  out; wr_full  in  controller write FIFO.
REQ-012 rd_en  out; rd_data[31:0] / rd_empty  in  controller read FIFO.
REQ-013 overflow_o  out  1  sticky: request dropped.
REQ-014 timeout_o  out  1  sticky read timeout (see Configuration).

Function
REQ-015 cmd_byte_addr SHALL be {addr,2'b00}; cmd_bl SHALL be 0 (one word); wr_mask SHALL be 4'h0; cmd_instr 3'b000 write, 3'b001 read.
REQ-016 FSM states: IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, RD_ACK.
REQ-017 IDLE: we_i latches addr/data -> WR_DATA; else pop_i latches addr -> RD_CMD; else pending slot valid -> dispatch it the same way.
REQ-018 WR_DATA: wr_en=1 with latched data only when wr_full=0, then -> WR_CMD; otherwise hold.
REQ-019 WR_CMD: cmd_en=1 (write) only when cmd_full=0, then -> IDLE; otherwise hold.
REQ-020 RD_CMD: cmd_en=1 (read) only when cmd_full=0, then -> RD_WAIT.
REQ-021 RD_WAIT: when rd_empty=0, rd_en=1 for one cycle, rd_data captured into data_o -> RD_ACK.
REQ-022 RD_ACK: ack_o=1 for exactly one cycle -> IDLE; read latency from pop_i with idle controller and data already present SHALL be 4 cycles (RD_CMD, RD_WAIT, RD_ACK registered).
REQ-023 cmd_en, wr_en, rd_en SHALL each be asserted at most one cycle per request.
REQ-024 A request arriving while FSM is not IDLE SHALL be stored in a one-entry pending slot (kind, addr, data).
REQ-025 we_i and pop_i in the same cycle: write served/stored first, read goes to pending slot; if slot unavailable the read is dropped.
REQ-026 Request arriving with pending slot full SHALL be dropped and set overflow_o; existing slot contents unchanged.
REQ-027 Writes SHALL never produce ack_o.

Reset
REQ-028 rst_n=0 SHALL force IDLE, clear pending slot, data_o=32'h0, ack_o/cmd_en/wr_en/rd_en=0, overflow_o=0, timeout_o=0, timeout counter=0.
REQ-029 Reset mid-operation SHALL abandon the transaction with no further controller strobes; in-flight controller read data is not drained.

Configuration
REQ-030 Macro DRAM_PEEK_TIMEOUT_EN defined: 16-bit counter runs in RD_WAIT; after 65535 cycles without rd_empty=0, data_o=32'hdeadbeef, ack_o pulses, timeout_o set, FSM -> IDLE.
REQ-031 Macro undefined: RD_WAIT waits indefinitely; timeout_o tied to 0; no counter logic.

Verification
REQ-032 Write: we_i, addr 28'h0000010, data 32'h12345678 -> one wr_en with 32'h12345678, then one cmd_en instr 000, byte_addr 30'h40, no ack_o.
REQ-033 Read: pop_i addr 28'h0000004, rd_empty drops 2 cycles after cmd_en with rd_data 32'hcafef00d -> one rd_en, ack_o one cycle, data_o 32'hcafef00d.
REQ-034 Backpressure: cmd_full=1 for 10 cycles during write -> cmd_en held off, issued once on first cycle cmd_full=0.
REQ-035 Back-to-back: we_i then pop_i next cycle -> write completes, read dispatched from pending slot, ack_o once, overflow_o=0; third request during both -> overflow_o=1.
REQ-036 With DRAM_PEEK_TIMEOUT_EN: pop_i, rd_empty held 1 -> ack_o after 65535 RD_WAIT cycles, data_o 32'hdeadbeef, timeout_o=1; rst_n=0 clears it.
